// File: rtl/load_store_ctrl_if.sv
// Bus bundle between main control / data memory and the load-store controller.
// The optional op_unsigned signal exists only when LSU_UNSIGNED_EN is defined.
interface load_store_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  // Request side
  logic              req;
  logic              op_store;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
`ifdef LSU_UNSIGNED_EN
  logic              op_unsigned;
`endif
  // Memory side
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  // Load result / status
  logic [1:0]        size_sel;
  logic [31:0]       ld_word;
  logic [15:0]       ld_half;
  logic [7:0]        ld_byte;
  logic              load_wr;
  logic              busy;
  logic              done;
  logic              misalign;

  // Main control + memory
  modport master (
    output req, op_store, op_size, addr, wdata, mem_rdata,
`ifdef LSU_UNSIGNED_EN
    output op_unsigned,
`endif
    input  mem_addr, mem_wr, mem_wdata, size_sel, ld_word, ld_half, ld_byte,
    input  load_wr, busy, done, misalign
  );

  // Load-store controller
  modport slave (
    input  req, op_store, op_size, addr, wdata, mem_rdata,
`ifdef LSU_UNSIGNED_EN
    input  op_unsigned,
`endif
    output mem_addr, mem_wr, mem_wdata, size_sel, ld_word, ld_half, ld_byte,
    output load_wr, busy, done, misalign
  );
endinterface

// File: rtl/load_store_ctrl.sv
// Multicycle data-memory access sequencer: loads, word stores and
// read-modify-write byte/half stores, with lane extraction for the load mux.
// Optional macro LSU_UNSIGNED_EN adds op_unsigned (lbu/lhu zero-extension).
module load_store_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_ctrl_if.slave  bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdWait = 3'd1;
  localparam logic [2:0] StWr     = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
  localparam logic [2:0] StErr    = 3'd4;

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              store_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [15:0]       half_q;
  logic [7:0]        byte_q;
`ifdef LSU_UNSIGNED_EN
  logic              uns_q;
  logic [31:0]       ldw_q;
`endif

  logic        accept;
  logic        capture;
  logic        fault;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] merged;

  // Alignment fault of the incoming request
  always_comb begin
    fault = 1'b0;
    case (bus.op_size)
      2'b01:   fault = bus.addr[0];
      2'b11:   fault = |bus.addr[1:0];
      2'b10:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

  // Next-state, latency counter and acceptance/capture strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          accept = 1'b1;
          cnt_d  = CntInit;
          if (fault) begin
            state_d = StErr;
          end else if (bus.op_store && bus.op_size == 2'b11) begin
            state_d = StWr;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          // Only partial stores reach RD_WAIT with store set
          state_d = store_q ? StWr : StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lane selection straight from the memory word, using the latched address
  always_comb begin
    rd_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    rd_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  end

  // Request latch at acceptance, read-data capture at the last RD_WAIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      half_q  <= 16'd0;
      byte_q  <= 8'd0;
`ifdef LSU_UNSIGNED_EN
      uns_q   <= 1'b0;
      ldw_q   <= 32'd0;
`endif
    end else if (accept) begin
      store_q <= bus.op_store;
      size_q  <= bus.op_size;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
`ifdef LSU_UNSIGNED_EN
      uns_q   <= bus.op_unsigned;
`endif
    end else if (capture) begin
      word_q <= bus.mem_rdata;
      half_q <= rd_half;
      byte_q <= rd_byte;
`ifdef LSU_UNSIGNED_EN
      // Unsigned sub-word load: hand the mux a pre-extended word
      if (!store_q && uns_q && size_q != 2'b11) begin
        ldw_q  <= (size_q == 2'b00) ? {24'd0, rd_byte} : {16'd0, rd_half};
        size_q <= 2'b11;
      end else begin
        ldw_q  <= bus.mem_rdata;
      end
`endif
    end
  end

  // Read-modify-write merge of the store lane into the captured word
  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wr    = (state_q == StWr);
  assign bus.mem_wdata = (state_q != StWr) ? 32'd0 :
                         (size_q == 2'b11) ? wdata_q : merged;
  assign bus.size_sel  = size_q;
`ifdef LSU_UNSIGNED_EN
  assign bus.ld_word   = ldw_q;
`else
  assign bus.ld_word   = word_q;
`endif
  assign bus.ld_half   = half_q;
  assign bus.ld_byte   = byte_q;
  assign bus.load_wr   = (state_q == StDone) && !store_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone) || (state_q == StErr);
  assign bus.misalign  = (state_q == StErr);

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl with MEM_LAT=2.
module tb_load_store_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_ctrl_if #(.ADDR_W(32)) bus ();

  load_store_ctrl #(
    .MEM_LAT (2),
    .ADDR_W  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request; returns in cycle N+1
  task automatic start(input logic st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic uns);
    bus.req      = 1'b1;
    bus.op_store = st;
    bus.op_size  = sz;
    bus.addr     = a;
    bus.wdata    = wd;
`ifdef LSU_UNSIGNED_EN
    bus.op_unsigned = uns;
`else
    if (uns) $display("note: op_unsigned ignored in this build");
`endif
    tick();
    bus.req = 1'b0;
  endtask

  // From cycle N+1, run until done (bounded); reports done cycle and writes seen
  task automatic run_to_done(output int dcyc, output int wrs, output int wcyc,
                             output logic [31:0] wdat, output logic [31:0] waddr);
    dcyc  = 1;
    wrs   = 0;
    wcyc  = 0;
    wdat  = 32'd0;
    waddr = 32'd0;
    while (!bus.done && dcyc < 20) begin
      if (bus.mem_wr) begin
        wrs++;
        wcyc  = dcyc;
        wdat  = bus.mem_wdata;
        waddr = bus.mem_addr;
      end
      tick();
      dcyc++;
    end
    if (bus.mem_wr) wrs++;
  endtask

  task automatic misal(input string tag, input logic st, input logic [1:0] sz,
                       input logic [31:0] a);
    start(st, sz, a, 32'h0, 1'b0);
    check({tag, "_misalign"}, bus.misalign, 1);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_memwr"}, bus.mem_wr, 0);
    check({tag, "_loadwr"}, bus.load_wr, 0);
    tick();
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int          d, w, wc, nwr;
    logic [31:0] wd, wa;

    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.op_store = 1'b0;
    bus.op_size  = 2'b00;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    bus.mem_rdata = 32'h0;
`ifdef LSU_UNSIGNED_EN
    bus.op_unsigned = 1'b0;
`endif
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_memwr", bus.mem_wr, 0);
    check("rst_sizesel", bus.size_sel, 0);
    check("rst_ldword", bus.ld_word, 0);
    check("rst_memaddr", bus.mem_addr, 0);
    tick();
    reset = 1'b0;
    tick();

    // lw 0x100
    bus.mem_rdata = 32'hDEADBEEF;
    start(1'b0, 2'b11, 32'h100, 32'h0, 1'b0);
    check("lw_memaddr", bus.mem_addr, 32'h100);
    check("lw_busy", bus.busy, 1);
    run_to_done(d, w, wc, wd, wa);
    check("lw_done_cyc", d, 3);
    check("lw_no_write", w, 0);
    check("lw_ldword", bus.ld_word, 32'hDEADBEEF);
    check("lw_sizesel", bus.size_sel, 2'b11);
    check("lw_loadwr", bus.load_wr, 1);
    tick();
    check("lw_idle", bus.busy, 0);
    check("lw_done_pulse", bus.done, 0);

    // lb 0x103
    bus.mem_rdata = 32'h80FF1234;
    start(1'b0, 2'b00, 32'h103, 32'h0, 1'b0);
    run_to_done(d, w, wc, wd, wa);
    check("lb_done_cyc", d, 3);
    check("lb_ldbyte", bus.ld_byte, 8'h80);
    check("lb_sizesel", bus.size_sel, 2'b00);
    check("lb_loadwr", bus.load_wr, 1);
    tick();

    // lh 0x102
    start(1'b0, 2'b01, 32'h102, 32'h0, 1'b0);
    run_to_done(d, w, wc, wd, wa);
    check("lh_done_cyc", d, 3);
    check("lh_ldhalf", bus.ld_half, 16'h80FF);
    check("lh_sizesel", bus.size_sel, 2'b01);
    check("lh_ldword", bus.ld_word, 32'h80FF1234);
    tick();

    // sb 0x201
    bus.mem_rdata = 32'h11223344;
    start(1'b1, 2'b00, 32'h201, 32'h000000AB, 1'b0);
    run_to_done(d, w, wc, wd, wa);
    check("sb_writes", w, 1);
    check("sb_wr_cyc", wc, 3);
    check("sb_wdata", wd, 32'h1122AB44);
    check("sb_waddr", wa, 32'h200);
    check("sb_done_cyc", d, 4);
    check("sb_loadwr", bus.load_wr, 0);
    tick();

    // sh 0x202
    start(1'b1, 2'b01, 32'h202, 32'h00005566, 1'b0);
    run_to_done(d, w, wc, wd, wa);
    check("sh_wr_cyc", wc, 3);
    check("sh_wdata", wd, 32'h55663344);
    check("sh_done_cyc", d, 4);
    tick();

    // Alignment faults
    misal("sh203", 1'b1, 2'b01, 32'h203);
    misal("lw102", 1'b0, 2'b11, 32'h102);
    misal("sz10", 1'b0, 2'b10, 32'h100);

    // sw with req held high across the whole access
    bus.req      = 1'b1;
    bus.op_store = 1'b1;
    bus.op_size  = 2'b11;
    bus.addr     = 32'h300;
    bus.wdata    = 32'hCAFEF00D;
    tick();
    check("sw_memwr", bus.mem_wr, 1);
    check("sw_wdata", bus.mem_wdata, 32'hCAFEF00D);
    bus.addr  = 32'h304;
    bus.wdata = 32'h12345678;
    tick();
    check("sw_done", bus.done, 1);
    check("sw_done_nowr", bus.mem_wr, 0);
    tick();
    check("sw_after_done_idle", bus.busy, 0);
    check("sw_after_done_nowr", bus.mem_wr, 0);
    tick();
    check("sw2_memwr", bus.mem_wr, 1);
    check("sw2_wdata", bus.mem_wdata, 32'h12345678);
    check("sw2_memaddr", bus.mem_addr, 32'h304);
    bus.req = 1'b0;
    tick();
    check("sw2_done", bus.done, 1);
    tick();

    // Reset in RD_WAIT of an sb
    bus.mem_rdata = 32'h11223344;
    start(1'b1, 2'b00, 32'h201, 32'h000000AB, 1'b0);
    check("abort_busy_pre", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_memaddr", bus.mem_addr, 0);
    check("abort_ldword", bus.ld_word, 0);
    check("abort_sizesel", bus.size_sel, 0);
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_wr) nwr++;
      tick();
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_wr) nwr++;
      tick();
    end
    check("abort_no_write", nwr, 0);

`ifdef LSU_UNSIGNED_EN
    // lbu / lhu
    bus.mem_rdata = 32'h80FF1234;
    start(1'b0, 2'b00, 32'h103, 32'h0, 1'b1);
    run_to_done(d, w, wc, wd, wa);
    check("lbu_done_cyc", d, 3);
    check("lbu_ldword", bus.ld_word, 32'h00000080);
    check("lbu_sizesel", bus.size_sel, 2'b11);
    check("lbu_ldbyte", bus.ld_byte, 8'h80);
    tick();
    start(1'b0, 2'b01, 32'h102, 32'h0, 1'b1);
    run_to_done(d, w, wc, wd, wa);
    check("lhu_ldword", bus.ld_word, 32'h000080FF);
    check("lhu_sizesel", bus.size_sel, 2'b11);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_ctrl.md
Name: load_store_ctrl

Overview:
- Sequences every data-memory access of the multicycle CPU: loads (lb/lh/lw), full-word stores (sw), and partial stores (sb/sh) done as read-modify-write.
- Extracts the addressed byte/half/word lane from the memory word.
- Drives the 2-bit size selector of the downstream load-size/sign-extension mux (00 byte, 01 half, 11 word).
- Sits between main control, data memory and that mux; main control stalls while busy=1.

Parameters:
- MEM_LAT, 2, cycles from mem_addr valid (mem_wr=0) to mem_rdata valid; legal range 1..15.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  1  access request, sampled only in IDLE
- op_store  in  1  0 = load, 1 = store
- op_size  in  2  00 byte, 01 half, 11 word, 10 illegal
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, low bits used for byte/half
- mem_rdata  in  32  memory read data
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wr  out  1  memory write strobe, one cycle
- mem_wdata  out  32  memory write data
- size_sel  out  2  selector to the load-size mux
- ld_word  out  32  captured word (full input of the mux)
- ld_half  out  16  selected half (half input of the mux)
- ld_byte  out  8  selected byte (byte input of the mux)
- load_wr  out  1  one-cycle strobe: load result valid, write MDR/regfile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle alignment-fault pulse

Behaviour:
- States: IDLE, RD_WAIT, WR, DONE, ERR. Byte order is little-endian: byte k = [8k+7:8k]; half h = [16h+15:16h].
- Reset, asynchronous, takes effect immediately:
  - State goes to IDLE.
  - All outputs and registers go to 0, including size_sel=00 and mem_wr=0.
  - A partial store aborted before WR writes nothing.
- Acceptance:
  - In IDLE with req=1, latch op_store, op_size, addr and wdata.
  - While busy, req and op inputs are ignored.
  - req in the DONE/ERR cycle is ignored. The earliest next acceptance is the cycle after DONE/ERR.
- Alignment check, at acceptance:
  - A fault is any of: half with addr[0]=1; word with addr[1:0]≠00; op_size=10.
  - On a fault: go to ERR.
  - ERR lasts one cycle with misalign=1, done=1, load_wr=0, mem_wr=0. No memory access is made. Then IDLE.
- Load, accepted in cycle N:
  - RD_WAIT during cycles N+1..N+MEM_LAT, with the counter counting MEM_LAT-1 down to 0.
  - Capture mem_rdata into ld_word at the end of cycle N+MEM_LAT.
  - DONE in cycle N+MEM_LAT+1: done=1, load_wr=1.
- Store word: WR in cycle N+1 (mem_wr=1, mem_wdata=wdata), then DONE in N+2.
- Store byte/half:
  - RD_WAIT and capture exactly as for a load.
  - WR in N+MEM_LAT+1: mem_wdata = captured word with byte addr[1:0] replaced by wdata[7:0], or half addr[1] replaced by wdata[15:0]. Other lanes are unchanged.
  - DONE in N+MEM_LAT+2, with load_wr=0.
- Outputs held until the next capture or reset:
  - ld_half = half addr[1] of ld_word; ld_byte = byte addr[1:0] of ld_word.
  - size_sel = latched op_size, updated at acceptance.
- mem_addr is held from acceptance until the next acceptance. mem_wr is high only in WR.
- The counter reloads at every acceptance; a back-to-back request after DONE behaves identically.

Optional Feature:
- Macro LSU_UNSIGNED_EN.
- When defined:
  - Adds input op_unsigned (1 bit), latched at acceptance.
  - For an unsigned byte/half load, DONE shows size_sel=11 and ld_word = the zero-extended field. The mux therefore passes it without sign extension (lbu/lhu).
  - ld_half and ld_byte are unchanged.
  - For stores, op_unsigned is ignored.
- When undefined: the port is absent, and sub-word loads are sign-extended downstream via size_sel 00/01.

Test Plan (MEM_LAT=2):
- lw addr=0x100, mem_rdata=0xDEADBEEF → mem_addr=0x100; DONE 3 cycles after req with ld_word=0xDEADBEEF, size_sel=11, load_wr=1, done=1, mem_wr never high.
- lb addr=0x103, mem_rdata=0x80FF1234 → ld_byte=0x80, size_sel=00, done at N+3. lh addr=0x102 on the same word → ld_half=0x80FF, size_sel=01.
- sb addr=0x201, wdata=0x000000AB, mem_rdata=0x11223344 → WR at N+3 with mem_wdata=0x1122AB44, mem_addr=0x200; done at N+4.
- sh addr=0x203 → misalign=1 and done=1 at N+1, no mem_wr, busy low at N+2. lw addr=0x102 → same. op_size=10 → same.
- sw addr=0x300, wdata=0xCAFEF00D → mem_wr=1 at N+1 with data 0xCAFEF00D, done at N+2. A second req held high during busy is ignored; a req in the cycle after DONE is accepted.
- Reset asserted in RD_WAIT of an sb → outputs 0 immediately, no write ever issued. With LSU_UNSIGNED_EN, lbu addr=0x103, data 0x80FF1234 → ld_word=0x00000080, size_sel=11.
